// File: rtl/trena_transmissor_serial.sv
// Serial transmitter for the tape-measure datapath.
// Sends the three latched BCD digits plus a terminator as 7E2 ASCII frames.
module trena_transmissor_serial #(
  parameter int         CLK_DIV    = 434,
  parameter logic [6:0] TERMINADOR = 7'h23
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       transmitir,
  input  logic [3:0] centena,
  input  logic [3:0] dezena,
  input  logic [3:0] unidade,
  output logic       saida_serial,
  output logic       envio_pronto,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CARREGA = 3'd1,
    ENVIA   = 3'd2,
    PROXIMO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t     estado, prox_estado;
  logic [CW-1:0] cnt_baud;
  logic [3:0]  cnt_bit;
  logic [1:0]  indice;
  logic [3:0]  cen_r, dez_r, uni_r;
  logic [10:0] quadro;     // bit 0 is the bit currently on the line
  logic [6:0]  caractere;
  logic        fim_bit;

  assign fim_bit = (cnt_baud == CW'(CLK_DIV - 1));

  // Character for the current index, built from the latched digits
  always_comb begin
    caractere = TERMINADOR;
    case (indice)
      2'd0:    caractere = 7'h30 + {3'b000, cen_r};
      2'd1:    caractere = 7'h30 + {3'b000, dez_r};
      2'd2:    caractere = 7'h30 + {3'b000, uni_r};
      default: caractere = TERMINADOR;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= IDLE;
    else        estado <= prox_estado;
  end

  // Next-state logic
  always_comb begin
    prox_estado = estado;
    case (estado)
      IDLE:    if (transmitir) prox_estado = CARREGA;
      CARREGA: prox_estado = ENVIA;
      ENVIA:   if (fim_bit && cnt_bit == 4'd10) prox_estado = PROXIMO;
      PROXIMO: prox_estado = (indice != 2'd3) ? CARREGA : FIM;
      FIM:     prox_estado = IDLE;
      default: prox_estado = IDLE;
    endcase
  end

  // Datapath: digit latch, frame shift register, bit/baud counters, index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_baud <= '0;
      cnt_bit  <= '0;
      indice   <= '0;
      cen_r    <= '0;
      dez_r    <= '0;
      uni_r    <= '0;
      quadro   <= '1;
    end else begin
      case (estado)
        IDLE: if (transmitir) begin
          cen_r  <= centena;
          dez_r  <= dezena;
          uni_r  <= unidade;
          indice <= '0;
        end
        CARREGA: begin
          // stop, stop, even parity, data LSB first, start
          quadro   <= {2'b11, ^caractere, caractere, 1'b0};
          cnt_baud <= '0;
          cnt_bit  <= '0;
        end
        ENVIA: begin
          if (fim_bit) begin
            cnt_baud <= '0;
            cnt_bit  <= cnt_bit + 4'd1;
            quadro   <= {1'b1, quadro[10:1]};
          end else begin
            cnt_baud <= cnt_baud + CW'(1);
          end
        end
        PROXIMO: indice <= indice + 2'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and the registered frame only
  always_comb begin
    saida_serial = 1'b1;
    if (estado == ENVIA) saida_serial = quadro[0];
    envio_pronto = (estado == FIM);
    ocupado      = (estado != IDLE);
    db_estado    = {1'b0, estado};
  end

endmodule
